// File: rtl/dma_rd_sched.sv
// Round-robin read scheduler: NCH DMA channels share one AXI4-Lite read master,
// one beat outstanding, each channel served for at most QUANTUM beats per turn.
module dma_rd_sched #(
    parameter  int NCH     = 4,
    parameter  int QUANTUM = 4,
    localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int QW      = $clog2(QUANTUM + 1)
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          cfg_valid,
    input  logic [CW-1:0] cfg_ch,
    input  logic [31:0]   cfg_addr,
    input  logic [15:0]   cfg_len,
    output logic [NCH-1:0] ch_busy,
    output logic [NCH-1:0] ch_done,
    output logic [NCH-1:0] ch_err,
    output logic [31:0]   dma_m_axi_araddr,
    output logic          dma_m_axi_arvalid,
    input  logic          dma_m_axi_arready,
    input  logic [31:0]   dma_m_axi_rdata,
    input  logic [1:0]    dma_m_axi_rresp,
    input  logic          dma_m_axi_rvalid,
    output logic          dma_m_axi_rready,
    output logic          out_valid,
    output logic [CW-1:0] out_ch,
    output logic [31:0]   out_data,
    output logic [1:0]    out_resp,
    input  logic          out_ready
);

    typedef enum logic [1:0] {IDLE, AR, R} state_t;

    state_t        state;
    logic [31:0]   addr_q [NCH];
    logic [15:0]   rem_q  [NCH];
    logic [NCH-1:0] busy_q;
    logic [NCH-1:0] err_q;
    logic [NCH-1:0] done_q;
    logic [CW-1:0] cur_ch;
    logic [CW-1:0] rr_ptr;
    logic [QW-1:0] qcnt;

    logic          cfg_acc;
    logic          beat;
    logic [15:0]   rem_nxt;
    logic [QW-1:0] qcnt_nxt;
    logic [CW-1:0] rr_nxt;
    logic [CW-1:0] sel;
    logic          found;
    int            j;

    assign cfg_acc  = cfg_valid && (int'(cfg_ch) < NCH) &&
                      !busy_q[cfg_ch] && (cfg_len != 16'd0);
    assign beat     = (state == R) && dma_m_axi_rvalid && out_ready;
    assign rem_nxt  = rem_q[cur_ch] - 16'd1;
    assign qcnt_nxt = qcnt + 1'b1;
    assign rr_nxt   = (int'(cur_ch) == NCH - 1) ? '0 : cur_ch + 1'b1;

    // First busy channel at or after rr_ptr, wrapping around.
    always_comb begin
        sel   = rr_ptr;
        found = 1'b0;
        j     = 0;
        for (int i = 0; i < NCH; i++) begin
            j = (int'(rr_ptr) + i) % NCH;
            if (!found && busy_q[CW'(j)]) begin
                found = 1'b1;
                sel   = CW'(j);
            end
        end
    end

    assign dma_m_axi_arvalid = (state == AR);
    assign dma_m_axi_araddr  = (state == AR) ? addr_q[cur_ch] : '0;
    assign dma_m_axi_rready  = (state == R) && out_ready;
    assign out_valid         = (state == R) && dma_m_axi_rvalid;
    assign out_ch            = cur_ch;
    assign out_data          = dma_m_axi_rdata;
    assign out_resp          = dma_m_axi_rresp;

    assign ch_busy = busy_q;
    assign ch_done = done_q;
    assign ch_err  = err_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state  <= IDLE;
            busy_q <= '0;
            err_q  <= '0;
            done_q <= '0;
            cur_ch <= '0;
            rr_ptr <= '0;
            qcnt   <= '0;
            for (int i = 0; i < NCH; i++) begin
                addr_q[i] <= '0;
                rem_q[i]  <= '0;
            end
        end else begin
            done_q <= '0;
            if (cfg_acc) begin
                addr_q[cfg_ch] <= cfg_addr;
                rem_q[cfg_ch]  <= cfg_len;
                err_q[cfg_ch]  <= 1'b0;
                busy_q[cfg_ch] <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (found) begin
                        cur_ch <= sel;
                        qcnt   <= '0;
                        state  <= AR;
                    end
                end
                AR: begin
                    if (dma_m_axi_arready)
                        state <= R;
                end
                R: begin
                    if (beat) begin
                        addr_q[cur_ch] <= addr_q[cur_ch] + 32'd4;
                        rem_q[cur_ch]  <= rem_nxt;
                        qcnt           <= qcnt_nxt;
                        if (dma_m_axi_rresp != 2'b00)
                            err_q[cur_ch] <= 1'b1;
                        if (rem_nxt == 16'd0) begin
                            busy_q[cur_ch] <= 1'b0;
                            done_q[cur_ch] <= 1'b1;
                        end
                        if (rem_nxt != 16'd0 && qcnt_nxt < QW'(QUANTUM)) begin
                            state <= AR;
                        end else begin
                            rr_ptr <= rr_nxt;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
